// File: rtl/hd_dma_loader_if.sv
// Bus bundle between the sector-transfer engine, the hard drive block and the
// word memory. The engine side uses the master modport.
interface hd_dma_loader_if #(
    parameter int MEM_ADDR_WIDTH = 10
);
    logic [6:0]                hd_track;
    logic [13:0]               hd_sector;
    logic [31:0]               hd_data_write;
    logic                      hd_flag_write;
    logic [31:0]               hd_data_read;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]               mem_data_write;
    logic                      mem_write_enable;
    logic [31:0]               mem_data_read;

    modport master (
        output hd_track, hd_sector, hd_data_write, hd_flag_write,
        output mem_addr, mem_data_write, mem_write_enable,
        input  hd_data_read, mem_data_read
    );

    modport slave (
        input  hd_track, hd_sector, hd_data_write, hd_flag_write,
        input  mem_addr, mem_data_write, mem_write_enable,
        output hd_data_read, mem_data_read
    );
endinterface

// File: rtl/hd_dma_loader.sv
// Sector-transfer engine: moves a block of 32-bit words between the hard
// drive and a synchronous word memory. Loads take one cycle per word, stores
// two (memory read latency). A run past the last track aborts with error.
module hd_dma_loader #(
    parameter int TRACKS         = 3,
    parameter int SECTORS        = 151,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      direction,
    input  logic [6:0]                start_track,
    input  logic [13:0]               start_sector,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_base,
    input  logic [13:0]               word_count,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    hd_dma_loader_if.master           bus
);

    localparam logic [6:0]  TRK_LIM = 7'(TRACKS);
    localparam logic [13:0] SEC_LIM = 14'(SECTORS);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        LOAD,
        MEM_RD,
        HD_WR,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [6:0]                track_q, track_d;
    logic [13:0]               sector_q, sector_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [13:0]               count_q, count_d;
    logic                      dir_q, dir_d;
    logic                      err_q, err_d;
    logic [6:0]                hold_track_q, hold_track_d;
    logic [13:0]               hold_sector_q, hold_sector_d;

    logic [13:0] sec_inc;
    logic [13:0] adv_sector;
    logic [6:0]  adv_track;
    logic        step;
    logic        xfer;

    // State and transfer counters; async reset returns everything to idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            track_q       <= '0;
            sector_q      <= '0;
            addr_q        <= '0;
            count_q       <= '0;
            dir_q         <= 1'b0;
            err_q         <= 1'b0;
            hold_track_q  <= '0;
            hold_sector_q <= '0;
        end else begin
            state_q       <= state_d;
            track_q       <= track_d;
            sector_q      <= sector_d;
            addr_q        <= addr_d;
            count_q       <= count_d;
            dir_q         <= dir_d;
            err_q         <= err_d;
            hold_track_q  <= hold_track_d;
            hold_sector_q <= hold_sector_d;
        end
    end

    // Next-state, position advance and bus outputs.
    always_comb begin
        state_d       = state_q;
        track_d       = track_q;
        sector_d      = sector_q;
        addr_d        = addr_q;
        count_d       = count_q;
        dir_d         = dir_q;
        err_d         = err_q;
        step          = 1'b0;
        xfer          = 1'b0;

        busy  = (state_q != IDLE);
        done  = (state_q == DONE);
        error = (state_q == DONE) && err_q;

        bus.hd_flag_write    = 1'b0;
        bus.mem_write_enable = 1'b0;
        bus.hd_data_write    = '0;
        bus.mem_data_write   = '0;
        bus.mem_addr         = addr_q;

        sec_inc = sector_q + 14'd1;
        if (sec_inc == SEC_LIM) begin
            adv_sector = '0;
            adv_track  = track_q + 7'd1;
        end else begin
            adv_sector = sec_inc;
            adv_track  = track_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    track_d  = start_track;
                    sector_d = start_sector;
                    addr_d   = mem_base;
                    count_d  = word_count;
                    dir_d    = direction;
                    err_d    = 1'b0;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (count_q == '0) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (track_q >= TRK_LIM || sector_q >= SEC_LIM) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = dir_q ? MEM_RD : LOAD;
                end
            end
            LOAD: begin
                xfer                 = 1'b1;
                step                 = 1'b1;
                bus.mem_write_enable = 1'b1;
                bus.mem_data_write   = bus.hd_data_read;
            end
            MEM_RD: begin
                state_d = HD_WR;
            end
            HD_WR: begin
                xfer              = 1'b1;
                step              = 1'b1;
                bus.hd_flag_write = 1'b1;
                bus.hd_data_write = bus.mem_data_read;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Shared word-completion step for LOAD and HD_WR; an advance onto a
        // nonexistent track aborts only if words are still outstanding.
        if (step) begin
            track_d  = adv_track;
            sector_d = adv_sector;
            addr_d   = addr_q + 1'b1;
            count_d  = count_q - 14'd1;
            if (count_q == 14'd1) begin
                state_d = DONE;
            end else if (adv_track == TRK_LIM) begin
                err_d   = 1'b1;
                state_d = DONE;
            end else begin
                state_d = (state_q == LOAD) ? LOAD : MEM_RD;
            end
        end

        hold_track_d  = xfer ? track_q  : hold_track_q;
        hold_sector_d = xfer ? sector_q : hold_sector_q;
        bus.hd_track  = xfer ? track_q  : hold_track_q;
        bus.hd_sector = xfer ? sector_q : hold_sector_q;
    end

endmodule

// File: tb/tb_hd_dma_loader.sv
// Directed bench for hd_dma_loader with a drive/memory model and a
// queue-based scoreboard monitor.
module tb_hd_dma_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic        direction;
    logic [6:0]  start_track;
    logic [13:0] start_sector;
    logic [9:0]  mem_base;
    logic [13:0] word_count;
    logic        busy;
    logic        done;
    logic        error;

    hd_dma_loader_if #(.MEM_ADDR_WIDTH(10)) bus ();

    hd_dma_loader #(
        .TRACKS(3),
        .SECTORS(151),
        .MEM_ADDR_WIDTH(10)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .direction(direction),
        .start_track(start_track),
        .start_sector(start_sector),
        .mem_base(mem_base),
        .word_count(word_count),
        .busy(busy),
        .done(done),
        .error(error),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          trk;
        int          sec;
        int          cyc;
    } wr_t;

    typedef struct {
        logic err;
        int   cyc;
    } dn_t;

    wr_t mem_q[$];
    wr_t hd_q[$];
    dn_t dn_q[$];

    logic [31:0] drive [1024];
    logic [31:0] mem   [1024];
    logic [31:0] mem_rd;
    logic [31:0] prog  [10] = '{32'h6C000000, 32'h6C400000, 32'h6C800000,
                                32'h6CC00000, 32'h6D000000, 32'h6D400000,
                                32'h6D800000, 32'h6DC00000, 32'h6E000000,
                                32'h70000000};
    int cyc;
    int total;
    int bad;
    int done_seen;

    function automatic logic [9:0] didx(input logic [6:0] t, input logic [13:0] s);
        return 10'(int'(t) * 151 + int'(s));
    endfunction

    function automatic logic [31:0] pat(input int t, input int s);
        if (t == 0 && s < 10) return prog[s];
        return 32'hD0000000 | (32'(t) << 16) | 32'(s);
    endfunction

    assign bus.hd_data_read  = (bus.hd_track < 7'd3 && bus.hd_sector < 14'd151) ?
                               drive[didx(bus.hd_track, bus.hd_sector)] : 32'h0;
    assign bus.mem_data_read = mem_rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_mw(input int addr, input int t, input int s, input int c);
        wr_t e;
        e.addr = addr; e.data = pat(t, s); e.trk = t; e.sec = s; e.cyc = c;
        mem_q.push_back(e);
    endtask

    task automatic push_hw(input logic [31:0] d, input int t, input int s, input int c);
        wr_t e;
        e.addr = 0; e.data = d; e.trk = t; e.sec = s; e.cyc = c;
        hd_q.push_back(e);
    endtask

    task automatic push_dn(input logic err, input int c);
        dn_t e;
        e.err = err; e.cyc = c;
        dn_q.push_back(e);
    endtask

    task automatic do_start(input logic dir, input int t, input int s, input int base,
                            input int n, output int k);
        @(negedge clock);
        start        = 1'b1;
        direction    = dir;
        start_track  = 7'(t);
        start_sector = 14'(s);
        mem_base     = 10'(base);
        word_count   = 14'(n);
        @(posedge clock);
        #1;
        k     = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n0;
        int i;
        n0 = done_seen;
        i  = 0;
        while (done_seen == n0 && i < budget) begin
            @(posedge clock);
            i++;
        end
        chk("done_within_budget", 64'(done_seen != n0), 64'(1));
    endtask

    initial begin
        int k;
        reset        = 1'b0;
        start        = 1'b0;
        direction    = 1'b0;
        start_track  = '0;
        start_sector = '0;
        mem_base     = '0;
        word_count   = '0;
        mem_rd       = '0;
        cyc          = 0;
        total        = 0;
        bad          = 0;
        done_seen    = 0;
        for (int i = 0; i < 1024; i++) begin
            mem[i]   = 32'h0;
            drive[i] = 32'h0;
        end
        for (int t = 0; t < 3; t++)
            for (int s = 0; s < 151; s++)
                drive[didx(7'(t), 14'(s))] = pat(t, s);

        fork
            // drive + memory model
            forever begin
                @(posedge clock);
                cyc++;
                if (bus.hd_flag_write && bus.hd_track < 7'd3 && bus.hd_sector < 14'd151)
                    drive[didx(bus.hd_track, bus.hd_sector)] = bus.hd_data_write;
                if (bus.mem_write_enable)
                    mem[bus.mem_addr] = bus.mem_data_write;
                mem_rd = mem[bus.mem_addr];
            end
            // scoreboard monitor
            forever begin
                @(negedge clock);
                if (reset) begin
                    if (bus.mem_write_enable) begin
                        chk("mem_wr_expected", 64'(mem_q.size() != 0), 64'(1));
                        if (mem_q.size() != 0) begin
                            wr_t e;
                            e = mem_q.pop_front();
                            chk("mem_addr", 64'(bus.mem_addr), 64'(e.addr));
                            chk("mem_data", 64'(bus.mem_data_write), 64'(e.data));
                            chk("ld_track", 64'(bus.hd_track), 64'(e.trk));
                            chk("ld_sector", 64'(bus.hd_sector), 64'(e.sec));
                            chk("mem_wr_cycle", 64'(cyc), 64'(e.cyc));
                        end
                    end
                    if (bus.hd_flag_write) begin
                        chk("hd_wr_expected", 64'(hd_q.size() != 0), 64'(1));
                        if (hd_q.size() != 0) begin
                            wr_t e;
                            e = hd_q.pop_front();
                            chk("hd_track", 64'(bus.hd_track), 64'(e.trk));
                            chk("hd_sector", 64'(bus.hd_sector), 64'(e.sec));
                            chk("hd_data", 64'(bus.hd_data_write), 64'(e.data));
                            chk("hd_wr_cycle", 64'(cyc), 64'(e.cyc));
                        end
                    end
                    if (done) begin
                        done_seen++;
                        chk("busy_in_done", 64'(busy), 64'(1));
                        chk("done_expected", 64'(dn_q.size() != 0), 64'(1));
                        if (dn_q.size() != 0) begin
                            dn_t e;
                            e = dn_q.pop_front();
                            chk("done_error", 64'(error), 64'(e.err));
                            chk("done_cycle", 64'(cyc), 64'(e.cyc));
                        end
                    end else if (error) begin
                        chk("error_without_done", 64'(error), 64'(0));
                    end
                end
            end
            begin
                #500000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        // reset state
        #12;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_error", 64'(error), 64'(0));
        chk("rst_mem_we", 64'(bus.mem_write_enable), 64'(0));
        chk("rst_hd_we", 64'(bus.hd_flag_write), 64'(0));
        chk("rst_hd_track", 64'(bus.hd_track), 64'(0));
        chk("rst_hd_sector", 64'(bus.hd_sector), 64'(0));
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        @(negedge clock);
        reset = 1'b1;

        // boot load: track 0 sectors 0..9 -> mem[0..9]
        do_start(1'b0, 0, 0, 0, 10, k);
        for (int i = 0; i < 10; i++) push_mw(i, 0, i, k + 1 + i);
        push_dn(1'b0, k + 11);
        wait_done(40);
        for (int i = 0; i < 10; i++) chk("boot_mem", 64'(mem[i]), 64'(prog[i]));

        // track wrap
        do_start(1'b0, 0, 149, 100, 4, k);
        push_mw(100, 0, 149, k + 1);
        push_mw(101, 0, 150, k + 2);
        push_mw(102, 1, 0, k + 3);
        push_mw(103, 1, 1, k + 4);
        push_dn(1'b0, k + 5);
        wait_done(40);
        chk("wrap_mem", 64'(mem[102]), 64'(32'hD0010000));

        // overflow abort: single write then done+error
        mem[201] = 32'h12345678;
        do_start(1'b0, 2, 150, 200, 3, k);
        push_mw(200, 2, 150, k + 1);
        push_dn(1'b1, k + 2);
        wait_done(40);
        #1;
        chk("ovf_busy_after", 64'(busy), 64'(0));
        chk("ovf_error_after", 64'(error), 64'(0));
        chk("ovf_mem_untouched", 64'(mem[201]), 64'(32'h12345678));

        // store: mem[16..17] -> drive[2][5..6]
        mem[16] = 32'hAAAA0000;
        mem[17] = 32'h00005555;
        do_start(1'b1, 2, 5, 16, 2, k);
        push_hw(32'hAAAA0000, 2, 5, k + 2);
        push_hw(32'h00005555, 2, 6, k + 4);
        push_dn(1'b0, k + 5);
        wait_done(40);
        chk("store_drive0", 64'(drive[didx(7'd2, 14'd5)]), 64'(32'hAAAA0000));
        chk("store_drive1", 64'(drive[didx(7'd2, 14'd6)]), 64'(32'h00005555));

        // degenerate: zero count, bad track, bad sector
        do_start(1'b0, 0, 0, 600, 0, k);
        push_dn(1'b0, k + 1);
        wait_done(20);
        do_start(1'b0, 3, 0, 600, 5, k);
        push_dn(1'b1, k + 1);
        wait_done(20);
        do_start(1'b1, 0, 151, 600, 5, k);
        push_dn(1'b1, k + 1);
        wait_done(20);

        // start pulses while busy are ignored
        do_start(1'b0, 1, 10, 300, 5, k);
        for (int i = 0; i < 5; i++) push_mw(300 + i, 1, 10 + i, k + 1 + i);
        push_dn(1'b0, k + 6);
        @(negedge clock);
        start        = 1'b1;
        direction    = 1'b1;
        start_track  = 7'd0;
        start_sector = 14'd0;
        mem_base     = 10'd0;
        word_count   = 14'd1;
        @(negedge clock);
        @(negedge clock);
        start = 1'b0;
        wait_done(40);

        // reset during the 4th LOAD cycle
        for (int i = 400; i < 410; i++) mem[i] = 32'hDEADBEEF;
        do_start(1'b0, 0, 20, 400, 8, k);
        for (int i = 0; i < 8; i++) push_mw(400 + i, 0, 20 + i, k + 1 + i);
        push_dn(1'b0, k + 9);
        repeat (4) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_mem_we", 64'(bus.mem_write_enable), 64'(0));
        chk("mid_rst_hd_we", 64'(bus.hd_flag_write), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_pending", 64'(mem_q.size()), 64'(5));
        mem_q.delete();
        dn_q.delete();
        repeat (3) @(negedge clock);
        chk("mid_rst_last_written", 64'(mem[402]), 64'(pat(0, 22)));
        chk("mid_rst_not_written", 64'(mem[403]), 64'(32'hDEADBEEF));
        reset = 1'b1;
        do_start(1'b0, 1, 0, 500, 3, k);
        for (int i = 0; i < 3; i++) push_mw(500 + i, 1, i, k + 1 + i);
        push_dn(1'b0, k + 4);
        wait_done(40);
        chk("post_rst_mem", 64'(mem[502]), 64'(32'hD0010002));

        repeat (3) @(negedge clock);
        chk("mem_q_empty", 64'(mem_q.size()), 64'(0));
        chk("hd_q_empty", 64'(hd_q.size()), 64'(0));
        chk("dn_q_empty", 64'(dn_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
